// File: rtl/reg_write_port_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared by the multi-cycle CPU register write-back
// path.
//   - Select encodings for the write-address and write-data muxes.
//   - Default data and register-index widths.
//   - Default link-register index used by jal-style writes.
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_LINK_REG   = 31;

  // Write-address select. WA_NONE means "no target": nothing is written.
  typedef enum logic [1:0] {
    WA_RT   = 2'b00,
    WA_RD   = 2'b01,
    WA_LINK = 2'b10,
    WA_NONE = 2'b11
  } wa_sel_e;

  // Write-data select.
  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_MEM  = 2'b01,
    WD_PC4  = 2'b10,
    WD_ZERO = 2'b11
  } wd_sel_e;

endpackage

// File: rtl/reg_write_port_mux.sv
// ---------------------------------------------------------------------------
// write_mux: generic 4:1 multiplexer used to pick the write-back address and
// the write-back data.
// Ports:
//   sel  - 2-bit select (00 -> in0, 01 -> in1, 10 -> in2, 11 -> in3)
//   in0..in3 - WIDTH-bit candidates
//   y    - selected value
// ---------------------------------------------------------------------------
module write_mux #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] y
);

  // NOTE: give every always_comb output a value before the case so no path
  // leaves it unassigned; an unassigned path infers a latch.
  always_comb begin
    y = in0;
    case (sel)
      2'b00:   y = in0;
      2'b01:   y = in1;
      2'b10:   y = in2;
      default: y = in3;
    endcase
  end

endmodule

// File: rtl/reg_write_port.sv
// ---------------------------------------------------------------------------
// reg_write_port: general register file of the multi-cycle CPU together with
// its write-back selection and the registered A/B read latches.
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   rd_addr1, rd_addr2   - read indices (rs, register-2 select)
//   rd_data1, rd_data2   - registered read data (A and B latches)
//   rt, rd               - instruction register fields
//   wa_sel               - write address: rt / rd / link / no write
//   wd_sel               - write data: alu_out / mem_data / pc_plus4 / zero
//   alu_out, mem_data, pc_plus4 - write-back data candidates
//   reg_write            - write-back strobe from the control FSM
//   wr_done              - one-cycle pulse when a register was written
//   wr_addr_last         - index of the most recent committed write
// Register 0 reads as zero and ignores writes. A commit and a read of the
// same index at one edge deliver the new data to that read latch.
// ---------------------------------------------------------------------------
module reg_write_port
  import cpu_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINK_REG   = DEF_LINK_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [1:0]            wa_sel,
  input  logic [1:0]            wd_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  reg_write,
  output logic                  wr_done,
  output logic [ADDR_WIDTH-1:0] wr_addr_last
);

  localparam int                    N_REGS    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LINK_ADDR = ADDR_WIDTH'(LINK_REG);
  localparam logic [ADDR_WIDTH-1:0] NO_ADDR   = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  logic [DATA_WIDTH-1:0] regs_q [N_REGS];
  logic [DATA_WIDTH-1:0] regs_d [N_REGS];
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  wr_done_q, wr_done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_last_q, wr_addr_last_d;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  commit;

  // The "no write" leg routes index 0, which commit already rejects; the
  // explicit WA_NONE check below keeps the intent independent of that.
  write_mux #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
    .sel (wa_sel),
    .in0 (rt),
    .in1 (rd),
    .in2 (LINK_ADDR),
    .in3 (NO_ADDR),
    .y   (wr_addr)
  );

  write_mux #(.WIDTH(DATA_WIDTH)) u_data_mux (
    .sel (wd_sel),
    .in0 (alu_out),
    .in1 (mem_data),
    .in2 (pc_plus4),
    .in3 (ZERO_DATA),
    .y   (wr_data)
  );

  assign commit = reg_write && (wa_sel != WA_NONE) && (wr_addr != NO_ADDR);

  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wr_addr] = wr_data;
    end

    // Entry 0 is never written, but forcing the read keeps it zero by
    // construction. Commit excludes index 0, so forwarding never hits it.
    rd_data1_d = (rd_addr1 == NO_ADDR) ? ZERO_DATA : regs_q[rd_addr1];
    if (commit && (wr_addr == rd_addr1)) begin
      rd_data1_d = wr_data;
    end

    rd_data2_d = (rd_addr2 == NO_ADDR) ? ZERO_DATA : regs_q[rd_addr2];
    if (commit && (wr_addr == rd_addr2)) begin
      rd_data2_d = wr_data;
    end

    wr_done_d      = commit;
    wr_addr_last_d = commit ? wr_addr : wr_addr_last_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register file is deliberately cleared on reset (the CPU
      // relies on zeroed registers), which forces flops instead of RAM.
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_data1_q     <= '0;
      rd_data2_q     <= '0;
      wr_done_q      <= 1'b0;
      wr_addr_last_q <= '0;
    end else begin
      regs_q         <= regs_d;
      rd_data1_q     <= rd_data1_d;
      rd_data2_q     <= rd_data2_d;
      wr_done_q      <= wr_done_d;
      wr_addr_last_q <= wr_addr_last_d;
    end
  end

  assign rd_data1     = rd_data1_q;
  assign rd_data2     = rd_data2_q;
  assign wr_done      = wr_done_q;
  assign wr_addr_last = wr_addr_last_q;

endmodule

// File: tb/tb_reg_write_port.sv
// ---------------------------------------------------------------------------
// tb_reg_write_port: directed self-checking bench for reg_write_port.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_reg_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, rt, rd, wr_addr_last;
  logic [31:0] rd_data1, rd_data2, alu_out, mem_data, pc_plus4;
  logic [1:0]  wa_sel, wd_sel;
  logic        reg_write, wr_done;

  int n_cmp = 0;
  int n_bad = 0;

  reg_write_port dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .rt           (rt),
    .rd           (rd),
    .wa_sel       (wa_sel),
    .wd_sel       (wd_sel),
    .alu_out      (alu_out),
    .mem_data     (mem_data),
    .pc_plus4     (pc_plus4),
    .reg_write    (reg_write),
    .wr_done      (wr_done),
    .wr_addr_last (wr_addr_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; reg_write = 1'b0; wa_sel = 2'b11; wd_sel = 2'b00;
    rt = '0; rd = '0; rd_addr1 = '0; rd_addr2 = '0;
    alu_out = '0; mem_data = '0; pc_plus4 = '0;

    // Reset state
    tick();
    rst = 1'b0;
    check("reset_rd1", rd_data1, 32'h0);
    check("reset_rd2", rd_data2, 32'h0);
    check("reset_done", {31'b0, wr_done}, 32'h0);
    check("reset_last", {27'b0, wr_addr_last}, 32'h0);

    // Preload r5 = 0x1234
    reg_write = 1'b1; wa_sel = 2'b00; rt = 5'd5; wd_sel = 2'b00;
    alu_out = 32'h0000_1234;
    tick();
    check("pre_done", {31'b0, wr_done}, 32'h1);
    check("pre_last", {27'b0, wr_addr_last}, 32'd5);
    reg_write = 1'b0; rd_addr1 = 5'd5;
    tick();
    check("pre_read", rd_data1, 32'h0000_1234);

    // Reset with a write pending: reset wins
    rst = 1'b1; reg_write = 1'b1; wa_sel = 2'b00; rt = 5'd5;
    alu_out = 32'h0000_9999;
    tick();
    rst = 1'b0; reg_write = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    check("rst_wr_rd1", rd_data1, 32'h0);
    check("rst_wr_done", {31'b0, wr_done}, 32'h0);
    check("rst_wr_last", {27'b0, wr_addr_last}, 32'h0);
    tick();
    check("rst_r5_rd1", rd_data1, 32'h0);
    check("rst_r5_rd2", rd_data2, 32'h0);

    // Write via rd field
    reg_write = 1'b1; wa_sel = 2'b01; rd = 5'd8; rt = 5'd4; wd_sel = 2'b00;
    alu_out = 32'hDEAD_BEEF; rd_addr1 = 5'd0;
    tick();
    check("wr_rd_done", {31'b0, wr_done}, 32'h1);
    check("wr_rd_last", {27'b0, wr_addr_last}, 32'd8);
    reg_write = 1'b0; rd_addr1 = 5'd8;
    tick();
    check("wr_rd_read", rd_data1, 32'hDEAD_BEEF);
    check("wr_rd_idle", {31'b0, wr_done}, 32'h0);
    check("rt_untouched", {27'b0, wr_addr_last}, 32'd8);

    // Link write
    reg_write = 1'b1; wa_sel = 2'b10; wd_sel = 2'b10; pc_plus4 = 32'h0040_0008;
    alu_out = 32'h1111_1111;
    tick();
    check("link_done", {31'b0, wr_done}, 32'h1);
    check("link_last", {27'b0, wr_addr_last}, 32'd31);
    reg_write = 1'b0; rd_addr2 = 5'd31;
    tick();
    check("link_read", rd_data2, 32'h0040_0008);

    // Write to r0 dropped
    reg_write = 1'b1; wa_sel = 2'b00; rt = 5'd0; wd_sel = 2'b01;
    mem_data = 32'hFFFF_FFFF; rd_addr2 = 5'd0;
    tick();
    check("r0_done", {31'b0, wr_done}, 32'h0);
    check("r0_last", {27'b0, wr_addr_last}, 32'd31);
    check("r0_read", rd_data2, 32'h0);

    // reg_write low with a valid target: nothing happens
    reg_write = 1'b0; wa_sel = 2'b01; rd = 5'd8; wd_sel = 2'b00;
    alu_out = 32'h0BAD_0BAD; rd_addr1 = 5'd8;
    tick();
    check("nostrobe_done", {31'b0, wr_done}, 32'h0);
    check("nostrobe_rd1", rd_data1, 32'hDEAD_BEEF);

    // Forwarding: r9 = 0x11 first, then overwrite while both ports read r9
    reg_write = 1'b1; wa_sel = 2'b00; rt = 5'd9; wd_sel = 2'b00;
    alu_out = 32'h0000_0011;
    tick();
    reg_write = 1'b0; rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    tick();
    check("fwd_old", rd_data1, 32'h0000_0011);
    reg_write = 1'b1; wa_sel = 2'b01; rd = 5'd9; wd_sel = 2'b01;
    mem_data = 32'hA5A5_A5A5;
    tick();
    check("fwd_rd1", rd_data1, 32'hA5A5_A5A5);
    check("fwd_rd2", rd_data2, 32'hA5A5_A5A5);
    check("fwd_last", {27'b0, wr_addr_last}, 32'd9);

    // No-write select with strobe high
    reg_write = 1'b1; wa_sel = 2'b11; rt = 5'd9; rd = 5'd9; wd_sel = 2'b00;
    alu_out = 32'h0000_0077;
    tick();
    check("none_done", {31'b0, wr_done}, 32'h0);
    check("none_rd1", rd_data1, 32'hA5A5_A5A5);
    check("none_last", {27'b0, wr_addr_last}, 32'd9);
    reg_write = 1'b0;
    tick();
    check("none_keep", rd_data2, 32'hA5A5_A5A5);

    // Back-to-back writes pulse wr_done each cycle; last one writes zero
    reg_write = 1'b1; wa_sel = 2'b01; rd = 5'd3; wd_sel = 2'b00;
    alu_out = 32'h0000_0055;
    tick();
    check("b2b_done1", {31'b0, wr_done}, 32'h1);
    tick();
    check("b2b_done2", {31'b0, wr_done}, 32'h1);
    wd_sel = 2'b11; rd_addr2 = 5'd3;
    tick();
    check("b2b_done3", {31'b0, wr_done}, 32'h1);
    check("zero_fwd", rd_data2, 32'h0);

    // Forward on one port only
    rd = 5'd8; wd_sel = 2'b00; alu_out = 32'h0000_0042;
    rd_addr1 = 5'd3; rd_addr2 = 5'd8;
    tick();
    check("one_rd1", rd_data1, 32'h0);
    check("one_rd2", rd_data2, 32'h0000_0042);
    check("one_last", {27'b0, wr_addr_last}, 32'd8);
    reg_write = 1'b0; rd_addr1 = 5'd31;
    tick();
    check("link_kept", rd_data1, 32'h0040_0008);
    check("final_idle", {31'b0, wr_done}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_write_port.md
Name: reg_write_port

Overview:
- Write-side counterpart of the register-file read-select path in the multi-cycle CPU.
- Owns the 32-entry general register file and selects the write-back destination (rt, rd or the link register) and the write-back data (ALUOut, MDR or PC+4).
- Performs the synchronous write in the write-back cycle.
- Provides two read ports with registered (A/B latch) outputs; a same-cycle write is forwarded into those outputs.

Parameters:
- DATA_WIDTH, 32, register and data word width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH entries)
- LINK_REG, 31, destination index used for jal-style link writes

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_addr1  input  ADDR_WIDTH  read port 1 index (rs)
- rd_addr2  input  ADDR_WIDTH  read port 2 index (from register-2 read select)
- rd_data1  output  DATA_WIDTH  registered read data 1 (A register)
- rd_data2  output  DATA_WIDTH  registered read data 2 (B register)
- rt  input  ADDR_WIDTH  instruction rt field
- rd  input  ADDR_WIDTH  instruction rd field
- wa_sel  input  2  write-address select: 00 rt, 01 rd, 10 LINK_REG, 11 no write
- wd_sel  input  2  write-data select: 00 alu_out, 01 mem_data, 10 pc_plus4, 11 zero
- alu_out  input  DATA_WIDTH  ALUOut register value
- mem_data  input  DATA_WIDTH  memory data register value
- pc_plus4  input  DATA_WIDTH  return address for link writes
- reg_write  input  1  write-back strobe from control FSM
- wr_done  output  1  one-cycle pulse: a register was actually written
- wr_addr_last  output  ADDR_WIDTH  index of the most recent committed write

Behaviour:
- Reset (rst=1 at clk edge): all 2^ADDR_WIDTH entries <= 0; rd_data1/rd_data2 <= 0; wr_done <= 0; wr_addr_last <= 0. Reset has priority over every other input, including a write in the same cycle.
- Write address mux (combinational, internal): wa_sel selects rt/rd/LINK_REG; 11 yields "no target".
- Write data mux (combinational, internal): wd_sel selects alu_out/mem_data/pc_plus4/0.
- Commit condition: reg_write=1 AND wa_sel!=11 AND selected address !=0.
- On commit at an edge: entry[addr] <= wdata; wr_done <= 1 for exactly that cycle; wr_addr_last <= addr.
- Otherwise: wr_done <= 0; file and wr_addr_last unchanged.
- Register 0 is hardwired zero:
  - writes to index 0 are dropped silently (no wr_done, wr_addr_last unchanged);
  - reads of index 0 always return 0.
- Read ports:
  - rd_data1 <= entry[rd_addr1] every edge (latency 1 cycle); rd_data2 likewise with rd_addr2.
  - No enable; outputs refresh every cycle, matching the multi-cycle A/B latches.
- Forwarding: if a commit and a read of the same nonzero index occur at the same edge, that read output takes the new wdata, not the stale entry. Both ports forward independently; both may forward at once.
- reg_write held high for multiple cycles: a write commits every cycle. Consecutive identical writes pulse wr_done each cycle.
- wa_sel/wd_sel/data inputs are sampled only at the edge; no internal latching between cycles.
- Reset asserted mid-sequence discards any in-progress write-back; the next write after reset release behaves normally.

Decomposition:
- Shared package (cpu_defs):
  - WA_RT/WA_RD/WA_LINK/WA_NONE and WD_ALU/WD_MEM/WD_PC4/WD_ZERO select encodings (2-bit);
  - DATA_WIDTH/ADDR_WIDTH defaults;
  - LINK_REG constant.
- One natural sub-module: write_mux (4:1 generic mux, parameterized width), instantiated twice for address and data selection.
- Storage, forwarding and read registers stay in reg_write_port.

Test Plan:
- Reset: preload r5=0x1234 via write, then pulse rst with reg_write=1, wa_sel=00, rt=5 -> next cycle all entries 0; rd_data1/2=0; wr_done=0.
- Write rd: reg_write=1, wa_sel=01, rd=8, wd_sel=00, alu_out=0xDEADBEEF -> wr_done=1, wr_addr_last=8; reading rd_addr1=8 next cycle gives rd_data1=0xDEADBEEF one cycle later.
- Link write: wa_sel=10, wd_sel=10, pc_plus4=0x00400008 -> entry31=0x00400008, wr_addr_last=31.
- Zero register: wa_sel=00, rt=0, mem_data=0xFFFFFFFF, reg_write=1 -> wr_done=0; rd_addr2=0 reads 0; wr_addr_last unchanged.
- Forwarding: same edge write r9=0xA5A5A5A5 with rd_addr1=rd_addr2=9 (old value 0x11) -> both rd_data1 and rd_data2 = 0xA5A5A5A5 after that edge.
- No-write select: reg_write=1, wa_sel=11 -> no entry changes; wr_done=0.
